// File: rtl/hart_sched_n_pkg.sv
// Shared constants and types for the hart state tracker / issue scheduler.
package hart_sched_n_pkg;

    localparam int unsigned DEF_HART_ID_W = 2;

    typedef enum logic [1:0] {
        HART_IDLE = 2'b00,
        HART_ACTI = 2'b01,
        HART_PEND = 2'b10
    } hart_sst_e;

    function automatic int unsigned num_harts(input int unsigned id_w);
        return 32'd1 << id_w;
    endfunction

endpackage

// File: rtl/hart_sched_n_rr_pick.sv
// Cyclic priority picker: first set request at or after start, wrapping.
module rr_pick #(
    parameter int unsigned N = 4,
    parameter int unsigned W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] start,
    output logic [N-1:0] grant,
    output logic [W-1:0] id,
    output logic         valid
);

    logic [W-1:0] idx;

    // N is a power of two, so W-bit addition wraps exactly at N.
    always_comb begin
        grant = '0;
        id    = '0;
        valid = 1'b0;
        idx   = '0;
        for (int unsigned i = 0; i < N; i++) begin
            idx = start + W'(i);
            if (!valid && req[idx]) begin
                valid      = 1'b1;
                grant[idx] = 1'b1;
                id         = idx;
            end
        end
    end

endmodule

// File: rtl/hart_sched_n.sv
// Per-hart idle/active/pending tracker with primary-hart tracking and
// round-robin issue selection for the IF stage.
module hart_sched_n
    import hart_sched_n_pkg::*;
#(
    parameter int unsigned HART_ID_W = DEF_HART_ID_W,
    parameter int unsigned RST_HART  = 0,
    localparam int unsigned NUM_HARTS = num_harts(HART_ID_W)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 id_hstart,
    input  logic                 id_hkill,
    input  logic [HART_ID_W-1:0] id_set_hid,
    input  logic [HART_ID_W-1:0] spec_hid,
    output logic [1:0]           get_hart_val,
    output logic                 get_hart_idle,
    output logic                 hctrl_err,
    input  logic                 i_cache_miss,
    input  logic [HART_ID_W-1:0] issue_hid,
    input  logic                 i_cache_fin,
    input  logic [HART_ID_W-1:0] i_cache_fin_hid,
    input  logic                 d_cache_miss,
    input  logic [HART_ID_W-1:0] ex_hart_id,
    input  logic                 d_cache_fin,
    input  logic [HART_ID_W-1:0] d_cache_fin_hid,
    input  logic                 issue_en,
    output logic                 issue_valid,
    output logic [HART_ID_W-1:0] issue_sel_hid,
    output logic [NUM_HARTS-1:0] idle_hstate,
    output logic [NUM_HARTS-1:0] acti_hstate,
    output logic [NUM_HARTS-1:0] prim_hstate
);

    localparam logic [NUM_HARTS-1:0] RST_ONEHOT = NUM_HARTS'(1) << RST_HART;
    localparam logic [HART_ID_W-1:0] RST_ID     = HART_ID_W'(RST_HART);

    logic [NUM_HARTS-1:0] started, ic_pend, dc_pend;
    logic [NUM_HARTS-1:0] n_started, n_ic, n_dc, next_acti, n_prim;
    logic [HART_ID_W-1:0] rr_ptr, prim_id, n_prim_id, prim_start;
    logic                 kill_ok, start_ok, ctrl_err, prim_keep;
    logic [NUM_HARTS-1:0] sel_grant, re_grant;
    logic [HART_ID_W-1:0] re_id;
    logic                 re_valid;
    hart_sst_e            hval;

    rr_pick #(.N(NUM_HARTS), .W(HART_ID_W)) u_issue_pick (
        .req   (acti_hstate),
        .start (rr_ptr + HART_ID_W'(1)),
        .grant (sel_grant),
        .id    (issue_sel_hid),
        .valid (issue_valid)
    );

    // With no primary, scanning from 0 yields the lowest-index active hart.
    assign prim_start = (prim_hstate == '0) ? '0 : prim_id + HART_ID_W'(1);

    rr_pick #(.N(NUM_HARTS), .W(HART_ID_W)) u_prim_pick (
        .req   (next_acti),
        .start (prim_start),
        .grant (re_grant),
        .id    (re_id),
        .valid (re_valid)
    );

    always_comb begin
        n_started = started;
        n_ic      = ic_pend;
        n_dc      = dc_pend;
        kill_ok   = id_hkill & started[id_set_hid];
        start_ok  = !id_hkill & id_hstart & !started[id_set_hid];
        ctrl_err  = (id_hkill | id_hstart) & !kill_ok & !start_ok;
        for (int unsigned h = 0; h < NUM_HARTS; h++) begin
            if (started[h]) begin
                if (i_cache_fin && i_cache_fin_hid == HART_ID_W'(h)) n_ic[h] = 1'b0;
                if (i_cache_miss && issue_hid == HART_ID_W'(h))      n_ic[h] = 1'b1;
                if (d_cache_fin && d_cache_fin_hid == HART_ID_W'(h)) n_dc[h] = 1'b0;
                if (d_cache_miss && ex_hart_id == HART_ID_W'(h))     n_dc[h] = 1'b1;
            end
        end
        // Hart control overrides any cache event on the same hart.
        if (kill_ok || start_ok) begin
            n_started[id_set_hid] = start_ok;
            n_ic[id_set_hid]      = 1'b0;
            n_dc[id_set_hid]      = 1'b0;
        end
    end

    assign next_acti = n_started & ~n_ic & ~n_dc;
    assign prim_keep = |(prim_hstate & next_acti);
    assign n_prim    = prim_keep ? prim_hstate : (re_valid ? re_grant : '0);
    assign n_prim_id = prim_keep ? prim_id : (re_valid ? re_id : '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            started     <= RST_ONEHOT;
            ic_pend     <= '0;
            dc_pend     <= '0;
            acti_hstate <= RST_ONEHOT;
            prim_hstate <= RST_ONEHOT;
            prim_id     <= RST_ID;
            rr_ptr      <= RST_ID;
            hctrl_err   <= 1'b0;
        end else begin
            started     <= n_started;
            ic_pend     <= n_ic;
            dc_pend     <= n_dc;
            acti_hstate <= next_acti;
            prim_hstate <= n_prim;
            prim_id     <= n_prim_id;
            hctrl_err   <= ctrl_err;
            if (issue_en && |sel_grant) rr_ptr <= issue_sel_hid;
        end
    end

    always_comb begin
        if (!started[spec_hid])                          hval = HART_IDLE;
        else if (ic_pend[spec_hid] || dc_pend[spec_hid]) hval = HART_PEND;
        else                                             hval = HART_ACTI;
    end

    assign get_hart_val  = hval;
    assign get_hart_idle = !started[spec_hid];
    assign idle_hstate   = ~started;

endmodule
